// File: rtl/sopc_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package sopc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic MST_IF = 1'b0;
    localparam logic MST_D  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sopc_sp_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module sopc_sp_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic [DATA_W/8-1:0]     we,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Read-during-write returns the old word; the arbiter never relies on it.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Fetch/data arbiter in front of one shared byte-writable word RAM, with wait states.
// Define SOPC_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module sopc_mem_arbiter
    import sopc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ce,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_data,
    output logic                  if_ready,
    input  logic                  d_ce,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_sel,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;

    logic                    grant;
    logic                    grant_id;
    logic                    gnt_id;
    logic                    lat_we;
    logic [SEL_W-1:0]        lat_sel;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic [DATA_W-1:0]       lat_wdata;

    logic [DEPTH_LOG2-1:0]   if_idx, d_idx;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [SEL_W-1:0]        ram_we;
    logic [DATA_W-1:0]       ram_q;
    logic                    resp_act;

    logic [DATA_W-1:0]       if_data_q, d_rdata_q;

    assign if_idx = if_addr[DEPTH_LOG2+1:2];
    assign d_idx  = d_addr[DEPTH_LOG2+1:2];

    // Upper address bits alias and the byte offset is ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[ADDR_W-1:DEPTH_LOG2+2], if_addr[1:0],
                                d_addr[ADDR_W-1:DEPTH_LOG2+2], d_addr[1:0]};

`ifdef SOPC_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= MST_D;
        end else if (grant) begin
            rr_ptr <= ~grant_id;
        end
    end

    always_comb begin
        grant = (state == IDLE) && (if_ce || d_ce);
        if (if_ce && d_ce) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = d_ce ? MST_D : MST_IF;
        end
    end
`else
    always_comb begin
        grant    = (state == IDLE) && (if_ce || d_ce);
        grant_id = d_ce ? MST_D : MST_IF;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id    <= MST_D;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            gnt_id <= grant_id;
            if (grant_id == MST_D) begin
                lat_we    <= d_we;
                lat_sel   <= d_sel;
                lat_idx   <= d_idx;
                lat_wdata <= d_wdata;
            end else begin
                lat_we    <= 1'b0;
                lat_sel   <= '0;
                lat_idx   <= if_idx;
            end
        end
    end

    // The RAM sees the requester's address during the grant cycle so the registered
    // read is ready even with zero wait states.
    always_comb begin
        if (state == IDLE) begin
            ram_addr = (grant_id == MST_D) ? d_idx : if_idx;
        end else begin
            ram_addr = lat_idx;
        end
    end

    assign resp_act = (state == RESP) && !rst;
    assign ram_we   = (resp_act && lat_we && (gnt_id == MST_D)) ? lat_sel : '0;

    sopc_sp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lat_wdata),
        .rdata (ram_q)
    );

    assign if_ready = resp_act && (gnt_id == MST_IF);
    assign d_ready  = resp_act && (gnt_id == MST_D);

    assign if_data = if_ready ? ram_q : if_data_q;
    assign d_rdata = d_ready ? (lat_we ? '0 : ram_q) : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (if_ready) begin
                if_data_q <= ram_q;
            end
            if (d_ready) begin
                d_rdata_q <= lat_we ? '0 : ram_q;
            end
        end
    end

endmodule
